// File: rtl/cpu_pkg.sv
`default_nettype none
// ============================================================================
// cpu_pkg
// Shared opcode/funct constants, ALU and sequencer enums, ALU helpers.
// Revision: 1.0
// ============================================================================
package cpu_pkg;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;

    localparam logic [2:0] F3_ADD_SUB = 3'b000;
    localparam logic [2:0] F3_SLL     = 3'b001;
    localparam logic [2:0] F3_SLT     = 3'b010;
    localparam logic [2:0] F3_SLTU    = 3'b011;
    localparam logic [2:0] F3_XOR     = 3'b100;
    localparam logic [2:0] F3_SRL_SRA = 3'b101;
    localparam logic [2:0] F3_OR      = 3'b110;
    localparam logic [2:0] F3_AND     = 3'b111;
    localparam logic [2:0] F3_BEQ     = 3'b000;
    localparam logic [2:0] F3_BNE     = 3'b001;

    localparam logic [6:0] F7_ALT = 7'b0100000;

    typedef enum logic [3:0] {
        ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR,
        ALU_SLT, ALU_SLTU, ALU_SLL, ALU_SRL, ALU_SRA
    } alu_op_e;

    typedef enum logic [1:0] {
        BOOT, FETCH, EXECUTE
    } seq_state_e;

    typedef enum logic [1:0] {
        WB_ALU, WB_MEM, WB_PC4, WB_IMM
    } wb_sel_e;

    function automatic alu_op_e alu_op_decode(input logic [2:0] funct3, input logic alt);
        alu_op_e op;
        op = ALU_ADD;
        case (funct3)
            F3_ADD_SUB: op = alt ? ALU_SUB : ALU_ADD;
            F3_SLL:     op = ALU_SLL;
            F3_SLT:     op = ALU_SLT;
            F3_SLTU:    op = ALU_SLTU;
            F3_XOR:     op = ALU_XOR;
            F3_SRL_SRA: op = alt ? ALU_SRA : ALU_SRL;
            F3_OR:      op = ALU_OR;
            F3_AND:     op = ALU_AND;
            default:    op = ALU_ADD;
        endcase
        return op;
    endfunction

    function automatic logic [31:0] alu_exec(input alu_op_e op, input logic [31:0] a,
                                             input logic [31:0] b);
        logic [31:0] y;
        y = '0;
        case (op)
            ALU_ADD:  y = a + b;
            ALU_SUB:  y = a - b;
            ALU_AND:  y = a & b;
            ALU_OR:   y = a | b;
            ALU_XOR:  y = a ^ b;
            ALU_SLT:  y = {31'b0, $signed(a) < $signed(b)};
            ALU_SLTU: y = {31'b0, a < b};
            ALU_SLL:  y = a << b[4:0];
            ALU_SRL:  y = a >> b[4:0];
            ALU_SRA:  y = $unsigned($signed(a) >>> b[4:0]);
            default:  y = '0;
        endcase
        return y;
    endfunction

endpackage
`default_nettype wire

// File: rtl/reg_file.sv
`default_nettype none
// ============================================================================
// reg_file
// 32x32 register file: two asynchronous reads, one synchronous write, x0 = 0.
// Revision: 1.0
// ============================================================================
module reg_file
    import cpu_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        reg_write,
    input  logic [4:0]  write_reg,
    input  logic [31:0] write_data,
    input  logic [4:0]  read_reg1,
    input  logic [4:0]  read_reg2,
    output logic [31:0] read_data1,
    output logic [31:0] read_data2
);

    logic [31:0] r_regs [32];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) begin
                r_regs[i] <= '0;
            end
        end else if (reg_write && (write_reg != 5'd0)) begin
            r_regs[write_reg] <= write_data;
        end
    end

    assign read_data1 = (read_reg1 == 5'd0) ? 32'd0 : r_regs[read_reg1];
    assign read_data2 = (read_reg2 == 5'd0) ? 32'd0 : r_regs[read_reg2];

endmodule
`default_nettype wire

// File: rtl/cpu_uart_top.sv
`default_nettype none
// ============================================================================
// cpu_uart_top
// RV32I-subset core, two-cycle FETCH/EXECUTE sequencer, optional boot copier
// enabled by macro BOOT_LOADER_EN.
// Revision: 1.0
// ============================================================================
module cpu_uart_top
    import cpu_pkg::*;
#(
    parameter int    CELL_NUMBERS = 256,
    parameter int    DMEM_WORDS   = 256,
    parameter string PROGRAM_FILE = "program.hex"
) (
    input  logic        clk,
    input  logic        rst,
    output logic [31:0] alu_result,
    output logic [31:0] pc
);

    localparam int IMEM_WORDS = CELL_NUMBERS / 4;
    localparam int IMEM_AW    = (IMEM_WORDS > 1) ? $clog2(IMEM_WORDS) : 1;
    localparam int DMEM_AW    = (DMEM_WORDS > 1) ? $clog2(DMEM_WORDS) : 1;

    logic [31:0] imem [IMEM_WORDS];
    logic [31:0] dmem [DMEM_WORDS];

    seq_state_e  r_state;
    seq_state_e  w_next_state;
    logic [31:0] r_pc;
    logic [31:0] r_ir;

`ifdef BOOT_LOADER_EN
    localparam seq_state_e RESET_STATE = BOOT;

    logic [31:0]        boot_rom [IMEM_WORDS];
    logic [IMEM_AW-1:0] r_boot_cnt;
    logic               w_boot_last;

    assign w_boot_last = (r_boot_cnt == IMEM_AW'(IMEM_WORDS - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_boot_cnt <= '0;
        end else if (r_state == BOOT) begin
            r_boot_cnt <= r_boot_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && (r_state == BOOT)) begin
            imem[r_boot_cnt] <= boot_rom[r_boot_cnt];
        end
    end
`else
    localparam seq_state_e RESET_STATE = FETCH;
`endif

    // Sequencer
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= RESET_STATE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
`ifdef BOOT_LOADER_EN
            BOOT:    w_next_state = w_boot_last ? FETCH : BOOT;
`endif
            FETCH:   w_next_state = EXECUTE;
            EXECUTE: w_next_state = FETCH;
            default: w_next_state = FETCH;
        endcase
    end

    // Instruction fields and immediates
    logic [6:0]  w_opcode;
    logic [4:0]  w_rd;
    logic [2:0]  w_funct3;
    logic [4:0]  w_rs1;
    logic [4:0]  w_rs2;
    logic [6:0]  w_funct7;
    logic [31:0] w_imm_i;
    logic [31:0] w_imm_s;
    logic [31:0] w_imm_b;
    logic [31:0] w_imm_j;
    logic [31:0] w_imm_u;

    assign w_opcode = r_ir[6:0];
    assign w_rd     = r_ir[11:7];
    assign w_funct3 = r_ir[14:12];
    assign w_rs1    = r_ir[19:15];
    assign w_rs2    = r_ir[24:20];
    assign w_funct7 = r_ir[31:25];
    assign w_imm_i  = {{20{r_ir[31]}}, r_ir[31:20]};
    assign w_imm_s  = {{20{r_ir[31]}}, r_ir[31:25], r_ir[11:7]};
    assign w_imm_b  = {{19{r_ir[31]}}, r_ir[31], r_ir[7], r_ir[30:25], r_ir[11:8], 1'b0};
    assign w_imm_j  = {{11{r_ir[31]}}, r_ir[31], r_ir[19:12], r_ir[20], r_ir[30:21], 1'b0};
    assign w_imm_u  = {r_ir[31:12], 12'b0};

    logic [31:0] w_rd1;
    logic [31:0] w_rd2;
    logic [31:0] w_pc_plus4;
    logic [31:0] w_load_data;
    logic [31:0] w_wb_data;
    logic [31:0] w_pc_next;
    logic [31:0] w_alu_b;
    alu_op_e     w_alu_op;
    wb_sel_e     w_wb_sel;
    logic        w_dec_reg_write;
    logic        w_dec_mem_write;
    logic        w_exec;
    logic        w_rf_we;
    logic        w_dmem_we;
    logic [DMEM_AW-1:0] w_dmem_idx;
    logic [IMEM_AW-1:0] w_imem_idx;

    assign w_pc_plus4 = r_pc + 32'd4;

    always_comb begin
        w_alu_op        = ALU_ADD;
        w_alu_b         = w_rd2;
        w_wb_sel        = WB_ALU;
        w_dec_reg_write = 1'b0;
        w_dec_mem_write = 1'b0;
        w_pc_next       = w_pc_plus4;
        case (w_opcode)
            OP_R: begin
                w_alu_op        = alu_op_decode(w_funct3, w_funct7 == F7_ALT);
                w_dec_reg_write = 1'b1;
            end
            OP_IMM: begin
                // Bit 30 is immediate data except for the shift-right encodings.
                w_alu_op        = alu_op_decode(w_funct3,
                                      (w_funct3 == F3_SRL_SRA) && (w_funct7 == F7_ALT));
                w_alu_b         = w_imm_i;
                w_dec_reg_write = 1'b1;
            end
            OP_LOAD: begin
                w_alu_b         = w_imm_i;
                w_wb_sel        = WB_MEM;
                w_dec_reg_write = 1'b1;
            end
            OP_STORE: begin
                w_alu_b         = w_imm_s;
                w_dec_mem_write = 1'b1;
            end
            OP_BRANCH: begin
                w_alu_op = ALU_SUB;
                if (((w_funct3 == F3_BEQ) && (w_rd1 == w_rd2)) ||
                    ((w_funct3 == F3_BNE) && (w_rd1 != w_rd2))) begin
                    w_pc_next = r_pc + w_imm_b;
                end
            end
            OP_JAL: begin
                w_wb_sel        = WB_PC4;
                w_dec_reg_write = 1'b1;
                w_pc_next       = r_pc + w_imm_j;
            end
            OP_LUI: begin
                w_wb_sel        = WB_IMM;
                w_dec_reg_write = 1'b1;
            end
            default: begin
                w_dec_reg_write = 1'b0;
            end
        endcase
    end

    assign alu_result = alu_exec(w_alu_op, w_rd1, w_alu_b);

    always_comb begin
        w_wb_data = alu_result;
        case (w_wb_sel)
            WB_MEM:  w_wb_data = w_load_data;
            WB_PC4:  w_wb_data = w_pc_plus4;
            WB_IMM:  w_wb_data = w_imm_u;
            default: w_wb_data = alu_result;
        endcase
    end

    // A reset arriving mid-EXECUTE suppresses both writebacks.
    assign w_exec    = (r_state == EXECUTE) && !rst;
    assign w_rf_we   = w_exec && w_dec_reg_write;
    assign w_dmem_we = w_exec && w_dec_mem_write;

    assign w_dmem_idx  = DMEM_AW'((alu_result >> 2) % DMEM_WORDS);
    assign w_imem_idx  = IMEM_AW'((r_pc >> 2) % IMEM_WORDS);
    assign w_load_data = dmem[w_dmem_idx];

    always_ff @(posedge clk) begin
        if (w_dmem_we) begin
            dmem[w_dmem_idx] <= w_rd2;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc <= '0;
            r_ir <= '0;
        end else begin
            if (r_state == FETCH) begin
                r_ir <= imem[w_imem_idx];
            end
            if (r_state == EXECUTE) begin
                r_pc <= w_pc_next;
            end
        end
    end

    assign pc = r_pc;

    reg_file rf (
        .clk        (clk),
        .rst        (rst),
        .reg_write  (w_rf_we),
        .write_reg  (w_rd),
        .write_data (w_wb_data),
        .read_reg1  (w_rs1),
        .read_reg2  (w_rs2),
        .read_data1 (w_rd1),
        .read_data2 (w_rd2)
    );

endmodule
`default_nettype wire

// File: tb/tb_cpu_uart_top.sv
`default_nettype none
// ============================================================================
// tb_cpu_uart_top
// Directed program run with hand-computed writeback values per instruction.
// Revision: 1.0
// ============================================================================
module tb_cpu_uart_top;

    localparam int CELLS = 128;
    localparam int WORDS = CELLS / 4;
    localparam int NPROG = 21;

    logic        clk;
    logic        rst;
    logic [31:0] alu_result;
    logic [31:0] pc;

    int checks = 0;
    int errors = 0;

    logic [31:0] prog [NPROG];

    cpu_uart_top #(
        .CELL_NUMBERS (CELLS),
        .DMEM_WORDS   (64),
        .PROGRAM_FILE ("")
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .alu_result (alu_result),
        .pc         (pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // From just after reset release to the first EXECUTE cycle.
    task automatic enter_first_exec();
`ifdef BOOT_LOADER_EN
        for (int i = 0; i < WORDS; i++) begin
            check("boot reg_write", 32'(dut.rf.reg_write), 32'd0);
            check("boot pc", pc, 32'd0);
            @(posedge clk); #1;
        end
`endif
        @(posedge clk); #1;
    endtask

    task automatic exec_step(input string tag, input logic [31:0] exp_pc, input logic exp_we,
                             input logic [4:0] exp_rd, input logic [31:0] exp_wd);
        check({tag, " pc"}, pc, exp_pc);
        check({tag, " reg_write"}, 32'(dut.rf.reg_write), 32'(exp_we));
        if (exp_we) begin
            check({tag, " write_reg"}, 32'(dut.rf.write_reg), 32'(exp_rd));
            check({tag, " write_data"}, dut.rf.write_data, exp_wd);
        end
        @(posedge clk); #1;
        check({tag, " fetch reg_write"}, 32'(dut.rf.reg_write), 32'd0);
        @(posedge clk); #1;
    endtask

    initial begin
        prog = '{32'hFFF00093, 32'h00100113, 32'h0020A1B3, 32'h00112233, 32'h0010A2B3,
                 32'h0020A3B3, 32'h0020B1B3, 32'h00113233, 32'h00500013, 32'h00000333,
                 32'h00202423, 32'h00802403, 32'h00000463, 32'h00700493, 32'h00300513,
                 32'h123455B7, 32'h0080066F, 32'h00700493, 32'h401106B3, 32'h0020D733,
                 32'h4020D7B3};
        for (int i = 0; i < WORDS; i++) begin
`ifdef BOOT_LOADER_EN
            dut.boot_rom[i] = (i < NPROG) ? prog[i] : 32'd0;
`else
            dut.imem[i] = (i < NPROG) ? prog[i] : 32'd0;
`endif
        end

        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            check("reset pc", pc, 32'd0);
            check("reset reg_write", 32'(dut.rf.reg_write), 32'd0);
        end
        rst = 1'b0;
        enter_first_exec();

        exec_step("addi x1",   32'd0,  1'b1, 5'd1,  32'hFFFFFFFF);
        exec_step("addi x2",   32'd4,  1'b1, 5'd2,  32'h00000001);
        exec_step("slt x3",    32'd8,  1'b1, 5'd3,  32'h00000001);
        exec_step("slt x4",    32'd12, 1'b1, 5'd4,  32'h00000000);
        exec_step("slt x5",    32'd16, 1'b1, 5'd5,  32'h00000000);
        exec_step("slt x7",    32'd20, 1'b1, 5'd7,  32'h00000001);
        exec_step("sltu x3",   32'd24, 1'b1, 5'd3,  32'h00000000);
        exec_step("sltu x4",   32'd28, 1'b1, 5'd4,  32'h00000001);
        exec_step("addi x0",   32'd32, 1'b1, 5'd0,  32'h00000005);
        exec_step("add x6",    32'd36, 1'b1, 5'd6,  32'h00000000);
        check("sw address", alu_result, 32'd8);
        exec_step("sw",        32'd40, 1'b0, 5'd0,  32'd0);
        exec_step("lw x8",     32'd44, 1'b1, 5'd8,  32'h00000001);
        exec_step("beq",       32'd48, 1'b0, 5'd0,  32'd0);
        exec_step("addi x10",  32'd56, 1'b1, 5'd10, 32'h00000003);
        exec_step("lui x11",   32'd60, 1'b1, 5'd11, 32'h12345000);
        exec_step("jal x12",   32'd64, 1'b1, 5'd12, 32'h00000044);
        exec_step("sub x13",   32'd72, 1'b1, 5'd13, 32'h00000002);
        check("srl alu_result", alu_result, 32'h7FFFFFFF);
        exec_step("srl x14",   32'd76, 1'b1, 5'd14, 32'h7FFFFFFF);

        // sra x15 is in EXECUTE now; reset aborts it.
        check("sra pc", pc, 32'd80);
        check("sra alu_result", alu_result, 32'hFFFFFFFF);
        rst = 1'b1;
        #1;
        check("mid reset reg_write", 32'(dut.rf.reg_write), 32'd0);
        @(posedge clk); #1;
        check("mid reset pc", pc, 32'd0);
        rst = 1'b0;
        enter_first_exec();

        exec_step("re addi x1", 32'd0, 1'b1, 5'd1, 32'hFFFFFFFF);
        exec_step("re addi x2", 32'd4, 1'b1, 5'd2, 32'h00000001);
        exec_step("re slt x3",  32'd8, 1'b1, 5'd3, 32'h00000001);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
